serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits (legal range 2..32).
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to begin a subtraction; sampled on clk rising edge.
REQ-005 a  input  WIDTH  minuend; sampled only on the edge that accepts start.
REQ-006 b  input  WIDTH  subtrahend; sampled only on the edge that accepts start.
REQ-007 busy  output  1  high while a subtraction is in progress.
REQ-008 done  output  1  single-cycle pulse; result valid.
REQ-009 diff  output  WIDTH  result a - b, modulo 2^WIDTH.
REQ-010 bout  output  1  final borrow out; 1 when a < b unsigned.
REQ-011 ovf  output  1  signed overflow flag; present only when SIGNED_OVF_EN is defined.

Function
REQ-012 The block SHALL implement FSM states IDLE, SHIFT, DONE, one bit per clock, LSB first.
REQ-013 In IDLE with start=1, the block SHALL latch a and b, clear the internal borrow and the bit counter, and enter SHIFT.
REQ-014 In SHIFT, each cycle SHALL compute d = a_i XOR b_i XOR br and br_next = (NOT a_i AND b_i) OR (NOT (a_i XOR b_i) AND br), then shift d into diff from the MSB side.
REQ-015 After exactly WIDTH SHIFT cycles, the block SHALL enter DONE, and bout SHALL equal the final borrow.
REQ-016 done SHALL be high for exactly the one cycle spent in DONE, WIDTH+1 rising edges after the accepting edge; the FSM SHALL then return to IDLE.
REQ-017 busy SHALL be high in SHIFT only, and low in IDLE and DONE.
REQ-018 start SHALL be ignored in SHIFT and DONE; no queuing, and latched operands are unaffected.
REQ-019 a and b changing after acceptance SHALL NOT affect the result.
REQ-020 diff and bout SHALL be valid from the DONE cycle and held unchanged in IDLE until the next accepted start; diff contents during SHIFT are undefined to the user.
REQ-021 start may be asserted back-to-back; a start in the cycle after DONE (IDLE) SHALL be accepted.
REQ-022 Boundary cases: a = b SHALL give diff = 0 and bout = 0; a = 0 with b = 2^WIDTH-1 SHALL give diff = 1 and bout = 1.

Reset
REQ-023 Asserting rst SHALL, asynchronously, force state IDLE, counter 0, borrow 0, and busy, done, diff, bout and ovf (if present) to 0.
REQ-024 Reset mid-SHIFT SHALL abort the operation with no done pulse; the first start after rst deasserts SHALL be accepted normally.

Configuration
REQ-025 Macro SIGNED_OVF_EN: when defined, the ovf port and logic SHALL exist.
REQ-026 With SIGNED_OVF_EN defined, ovf = (a_msb != b_msb) AND (diff_msb != a_msb), using the latched operands; ovf SHALL be valid and held under the same rules as diff.
REQ-027 Without SIGNED_OVF_EN, the ovf port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification (WIDTH=8)
REQ-028 Start with a=0x05, b=0x03 -> done exactly 9 edges after acceptance, diff=0x02, bout=0, busy high for 8 cycles.
REQ-029 Start with a=0x03, b=0x05 -> diff=0xFE, bout=1; then a=0x00, b=0xFF -> diff=0x01, bout=1; then a=0x5A, b=0x5A -> diff=0x00, bout=0.
REQ-030 With SIGNED_OVF_EN defined, start with a=0x80, b=0x01 -> diff=0x7F, ovf=1, bout=0; then a=0x7F, b=0xFF -> diff=0x80, ovf=1, bout=1; then a=0x10, b=0x01 -> ovf=0.
REQ-031 Start with a=0x05, b=0x03, pulse start again with a=0xFF, b=0x00 on cycle 3 of SHIFT, and change a/b mid-op -> result still 0x02 and only one done pulse.
REQ-032 Assert rst on cycle 4 of SHIFT -> all outputs 0 immediately with no done pulse; after release, start with a=0x10, b=0x01 -> diff=0x0F.
REQ-033 Start held high continuously with a=0x09, b=0x04 -> a done pulse every 10 cycles, each with diff=0x05.

Source files
------------

// File: rtl/serial_subtractor.sv
// ============================================================================
// serial_subtractor : bit-serial a - b, one bit per clock, LSB first.
// Optional macro SIGNED_OVF_EN adds the signed overflow output ovf.
// Revision 1.0
// ============================================================================
`default_nettype none

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SIGNED_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [CNT_W-1:0] cnt;
  logic             borrow;

  logic a_bit;
  logic b_bit;
  logic d_bit;
  logic borrow_next;
  logic last_bit;

  assign a_bit       = a_sh[0];
  assign b_bit       = b_sh[0];
  assign d_bit       = a_bit ^ b_bit ^ borrow;
  assign borrow_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & borrow);
  assign last_bit    = (cnt == LAST_BIT);

  // diff is used as the result shift register; it only settles at DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      cnt    <= '0;
      borrow <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh   <= a;
            b_sh   <= b;
            cnt    <= '0;
            borrow <= 1'b0;
            busy   <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          diff   <= {d_bit, diff[WIDTH-1:1]};
          a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
          borrow <= borrow_next;
          cnt    <= cnt + 1'b1;
          if (last_bit) begin
            bout  <= borrow_next;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef SIGNED_OVF_EN
  logic a_msb;
  logic b_msb;

  // Operand sign bits are captured at acceptance since the shifters lose them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        a_msb <= a[WIDTH-1];
        b_msb <= b[WIDTH-1];
      end
      if (state == SHIFT && last_bit) begin
        ovf <= (a_msb != b_msb) && (d_bit != a_msb);
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8).
`default_nettype none

module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SIGNED_OVF_EN
  logic             ovf;
`endif

  int errors = 0;
  int checks = 0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
`ifdef SIGNED_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Launch one operation from IDLE and wait for its done pulse.
  // lat = negedges after the accepting edge at which done is seen; nbusy = busy cycles.
  task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                        output int lat, output int nbusy);
    lat   = 0;
    nbusy = 0;
    @(negedge clk);
    a     = av;
    b     = bv;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    a = ~av;
    b = ~bv;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  int lat, nbusy, pulses, prev, got_diff;

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_diff", diff, 0);
    check("reset_bout", bout, 0);
    rst = 1'b0;

    // 5 - 3: latency, busy duration, result
    run_op(8'h05, 8'h03, lat, nbusy);
    check("lat_5_3", lat, 9);
    check("busy_cycles_5_3", nbusy, 8);
    check("busy_low_at_done", busy, 0);
    check("diff_5_3", diff, 8'h02);
    check("bout_5_3", bout, 0);
    @(negedge clk);
    check("done_single_cycle", done, 0);
    check("diff_held_idle", diff, 8'h02);

    run_op(8'h03, 8'h05, lat, nbusy);
    check("diff_3_5", diff, 8'hFE);
    check("bout_3_5", bout, 1);
    run_op(8'h00, 8'hFF, lat, nbusy);
    check("diff_0_ff", diff, 8'h01);
    check("bout_0_ff", bout, 1);
    run_op(8'h5A, 8'h5A, lat, nbusy);
    check("diff_eq", diff, 8'h00);
    check("bout_eq", bout, 0);

    // signed-overflow vectors; diff/bout checked in every build
    run_op(8'h80, 8'h01, lat, nbusy);
    check("diff_80_01", diff, 8'h7F);
    check("bout_80_01", bout, 0);
`ifdef SIGNED_OVF_EN
    check("ovf_80_01", ovf, 1);
`endif
    run_op(8'h7F, 8'hFF, lat, nbusy);
    check("diff_7f_ff", diff, 8'h80);
    check("bout_7f_ff", bout, 1);
`ifdef SIGNED_OVF_EN
    check("ovf_7f_ff", ovf, 1);
`endif
    run_op(8'h10, 8'h01, lat, nbusy);
    check("diff_10_01", diff, 8'h0F);
`ifdef SIGNED_OVF_EN
    check("ovf_10_01", ovf, 0);
`endif

    // start re-pulsed mid-SHIFT and operands disturbed: ignored
    @(negedge clk);
    a = 8'h05; b = 8'h03; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    pulses = 0;
    got_diff = 0;
    for (int i = 1; i <= 25; i++) begin
      @(negedge clk);
      if (i == 3) begin
        start = 1'b1; a = 8'hFF; b = 8'h00;
      end else if (i == 4) begin
        start = 1'b0; a = 8'hAA; b = 8'h55;
      end
      if (done) begin
        pulses++;
        got_diff = int'(diff);
      end
    end
    check("midop_pulses", pulses, 1);
    check("midop_diff", got_diff, 8'h02);

    // async reset on SHIFT cycle 4
    @(negedge clk);
    a = 8'h05; b = 8'h03; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst_async_busy", busy, 0);
    check("rst_async_done", done, 0);
    check("rst_async_diff", diff, 0);
    check("rst_async_bout", bout, 0);
`ifdef SIGNED_OVF_EN
    check("rst_async_ovf", ovf, 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("rst_no_done", pulses, 0);
    run_op(8'h10, 8'h01, lat, nbusy);
    check("post_rst_lat", lat, 9);
    check("post_rst_diff", diff, 8'h0F);

    // start held high: one done every 10 cycles
    @(negedge clk);
    a = 8'h09; b = 8'h04; start = 1'b1;
    pulses = 0;
    prev = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done) begin
        pulses++;
        check("b2b_diff", diff, 8'h05);
        if (prev >= 0) check("b2b_period", i - prev, 10);
        prev = i;
      end
    end
    start = 1'b0;
    check("b2b_pulses", pulses, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
